safety_island_responder: RTL and testbench

Target-side responder for the safety-island command interface. It accepts opcode/addr/data/id transactions from the initiator and executes register access, watchdog kick, lockstep compare and ECC syndrome check. It returns a completion on `ready`/`resp`/`status` and drives the safety monitor outputs. It sits at the boundary of the ASIL-D safety island, as the slave end of the command bus.

---
 rtl/safety_island_pkg.sv | 32 +++
 rtl/safety_island_responder_if.sv | 22 ++
 rtl/safety_island_ecc_syndrome.sv | 37 +++
 rtl/safety_island_responder.sv | 190 +++++++++++++++++++
 tb/tb_safety_island_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety-island command responder.
// Opcodes, completion codes, register offsets, FSM encoding and ERR_STATUS bit indices.
package safety_island_pkg;

  typedef enum logic [7:0] {
    OP_REG_WRITE    = 8'h01,
    OP_REG_READ     = 8'h02,
    OP_WDG_KICK     = 8'h10,
    OP_LOCKSTEP_CMP = 8'h20,
    OP_ECC_CHECK    = 8'h30
  } opcode_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] REG_CTRL       = 4'h0;
  localparam logic [3:0] REG_WDG_LOAD   = 4'h4;
  localparam logic [3:0] REG_SCRATCH    = 4'h8;
  localparam logic [3:0] REG_ERR_STATUS = 4'hC;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_ACK  = 2'd2;

  localparam int ERR_LOCKSTEP = 0;
  localparam int ERR_ECC      = 1;
  localparam int ERR_WDG      = 2;
  localparam int ERR_DECODE   = 3;

endpackage

// File: rtl/safety_island_responder_if.sv
// Command bus between safety-island initiator and responder: request fields held with
// valid until the one-cycle ready completion strobe, which carries resp/status.
interface safety_island_responder_if;
  logic [7:0]  opcode;
  logic [31:0] data;
  logic [31:0] addr;
  logic [7:0]  id;
  logic        valid;
  logic        ready;
  logic [1:0]  resp;
  logic [31:0] status;

  modport master (
    output opcode, data, addr, id, valid,
    input  ready, resp, status
  );

  modport slave (
    input  opcode, data, addr, id, valid,
    output ready, resp, status
  );
endinterface

// File: rtl/safety_island_ecc_syndrome.sv
// Hamming(38,32) syndrome generator, purely combinational: check bits at positions 1,2,4,..,32,
// data bits in the remaining positions in ascending order. Used only with SAFETY_ISLAND_ECC_EN.
module safety_island_ecc_syndrome (
  input  logic [31:0] data,
  input  logic [5:0]  check,
  output logic [5:0]  syndrome
);

  logic [38:1] cw;

  always_comb begin
    int unsigned di;
    int unsigned ci;
    di = 0;
    ci = 0;
    cw = '0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) == 0) begin
        cw[p] = check[ci[2:0]];
        ci++;
      end else begin
        cw[p] = data[di[4:0]];
        di++;
      end
    end
  end

  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= 38; p++) begin
      for (int i = 0; i < 6; i++) begin
        if (p[i]) syndrome[i] = syndrome[i] ^ cw[p];
      end
    end
  end

endmodule

// File: rtl/safety_island_responder.sv
// Safety-island target responder: fixed IDLE->EXEC->ACK, ready two cycles after valid is sampled,
// no internal backpressure. ECC_CHECK is implemented only with SAFETY_ISLAND_ECC_EN defined.
module safety_island_responder
  import safety_island_pkg::*;
#(
  parameter int WDG_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  safety_island_responder_if.slave  bus,
  output logic                      error,
  output logic                      lockstep_match,
  output logic [5:0]                ecc_status,
  output logic                      wdg_timeout
);

  state_t      state_q;
  logic [7:0]  op_q;
  logic [31:0] data_q;
  logic [31:0] addr_q;
  logic [7:0]  id_q;

  logic             ctrl_en_q;
  logic [31:0]      wdg_load_q;
  logic [31:0]      scratch_q;
  logic [3:0]       err_q;
  logic [WDG_W-1:0] wdg_cnt_q;
  logic             wdg_to_q;

  logic [1:0]  resp_q;
  logic [31:0] status_q;
  logic        lockstep_q;
  logic [5:0]  ecc_q;

  logic [5:0]  syndrome;
  logic        addr_ok;
  logic        wdg_fire;
  logic        wdg_reload;
  logic        exec;

  logic [1:0]  resp_nxt;
  logic [31:0] status_nxt;
  logic [31:0] rd_val;
  logic        is_read;
  logic [3:0]  err_set;
  logic [3:0]  err_clr;
  logic [3:0]  err_nxt;
  logic        wr_ctrl, wr_load, wr_scratch, kick, ls_upd, ecc_upd;

`ifdef SAFETY_ISLAND_ECC_EN
  safety_island_ecc_syndrome u_ecc (
    .data     (data_q),
    .check    (addr_q[5:0]),
    .syndrome (syndrome)
  );
`else
  assign syndrome = '0;
`endif

  assign exec     = (state_q == ST_EXEC);
  assign addr_ok  = (addr_q[31:4] == '0) && (addr_q[1:0] == 2'b00);
  assign wdg_fire = ctrl_en_q && (wdg_cnt_q == '0);

  always_comb begin
    resp_nxt   = RESP_OKAY;
    rd_val     = '0;
    is_read    = 1'b0;
    err_set    = '0;
    err_clr    = '0;
    wr_ctrl    = 1'b0;
    wr_load    = 1'b0;
    wr_scratch = 1'b0;
    kick       = 1'b0;
    ls_upd     = 1'b0;
    ecc_upd    = 1'b0;
    err_set[ERR_WDG] = wdg_fire;
    if (exec) begin
      case (op_q)
        OP_REG_WRITE: begin
          if (!addr_ok) resp_nxt = RESP_DECERR;
          else begin
            case (addr_q[3:0])
              REG_CTRL:       wr_ctrl    = 1'b1;
              REG_WDG_LOAD:   wr_load    = 1'b1;
              REG_SCRATCH:    wr_scratch = 1'b1;
              default:        err_clr    = data_q[3:0];
            endcase
          end
        end
        OP_REG_READ: begin
          if (!addr_ok) resp_nxt = RESP_DECERR;
          else begin
            is_read = 1'b1;
            case (addr_q[3:0])
              REG_CTRL:       rd_val = {31'h0, ctrl_en_q};
              REG_WDG_LOAD:   rd_val = wdg_load_q;
              REG_SCRATCH:    rd_val = scratch_q;
              default:        rd_val = {28'h0, err_q};
            endcase
          end
        end
        OP_WDG_KICK: kick = 1'b1;
        OP_LOCKSTEP_CMP: begin
          ls_upd = 1'b1;
          if (data_q != addr_q) begin
            resp_nxt              = RESP_SLVERR;
            err_set[ERR_LOCKSTEP] = 1'b1;
          end
        end
`ifdef SAFETY_ISLAND_ECC_EN
        OP_ECC_CHECK: begin
          ecc_upd = 1'b1;
          if (syndrome != '0) begin
            resp_nxt         = RESP_SLVERR;
            err_set[ERR_ECC] = 1'b1;
          end
        end
`endif
        default: begin
          resp_nxt            = RESP_DECERR;
          err_set[ERR_DECODE] = 1'b1;
        end
      endcase
    end
    // Hardware set wins over a simultaneous W1C of the same bit.
    err_nxt    = (err_q & ~err_clr) | err_set;
    status_nxt = is_read ? rd_val : {16'h0, id_q, 4'h0, err_nxt};
  end

  // Counter takes the load value as the FSM enters ACK, so it holds WDG_LOAD during ACK.
  assign wdg_reload = kick || (wr_ctrl && data_q[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      id_q       <= '0;
      ctrl_en_q  <= 1'b0;
      wdg_load_q <= '0;
      scratch_q  <= '0;
      err_q      <= '0;
      wdg_cnt_q  <= '0;
      wdg_to_q   <= 1'b0;
      resp_q     <= RESP_OKAY;
      status_q   <= '0;
      lockstep_q <= 1'b1;
      ecc_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.valid) begin
            op_q    <= bus.opcode;
            data_q  <= bus.data;
            addr_q  <= bus.addr;
            id_q    <= bus.id;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: state_q <= ST_ACK;
        default: state_q <= ST_IDLE;
      endcase

      err_q <= err_nxt;
      if (exec) begin
        resp_q   <= resp_nxt;
        status_q <= status_nxt;
      end
      if (ls_upd)     lockstep_q <= (data_q == addr_q);
      if (ecc_upd)    ecc_q      <= syndrome;
      if (wr_ctrl)    ctrl_en_q  <= data_q[0];
      if (wr_load)    wdg_load_q <= data_q;
      if (wr_scratch) scratch_q  <= data_q;

      if (wdg_reload)                       wdg_cnt_q <= WDG_W'(wdg_load_q);
      else if (ctrl_en_q && wdg_cnt_q != '0) wdg_cnt_q <= wdg_cnt_q - WDG_W'(1);
      wdg_to_q <= wdg_fire;
    end
  end

  assign bus.ready      = (state_q == ST_ACK);
  assign bus.resp       = resp_q;
  assign bus.status     = status_q;
  assign error          = |err_q;
  assign lockstep_match = lockstep_q;
  assign ecc_status     = ecc_q;
  assign wdg_timeout    = wdg_to_q;

endmodule

// File: tb/tb_safety_island_responder.sv
// Randomized bench for safety_island_responder against a transaction-level model,
// plus directed watchdog timing, decode, ECC and mid-transaction reset cases.
module tb_safety_island_responder;

  logic       clk;
  logic       rst_n;
  logic       error;
  logic       lockstep_match;
  logic [5:0] ecc_status;
  logic       wdg_timeout;

  safety_island_responder_if bus ();

  safety_island_responder #(.WDG_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .error          (error),
    .lockstep_match (lockstep_match),
    .ecc_status     (ecc_status),
    .wdg_timeout    (wdg_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference state: register file and sticky monitor outputs.
  logic        m_ctrl;
  logic [31:0] m_load;
  logic [31:0] m_scratch;
  logic [3:0]  m_err;
  logic        m_ls;
  logic [5:0]  m_ecc;
  logic        m_to;
  int          pos [32];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 1'b0; m_load = '0; m_scratch = '0; m_err = '0;
    m_ls = 1'b1; m_ecc = '0; m_to = 1'b0;
  endtask

  // Syndrome = XOR of codeword positions of set data bits, XOR the check bits at 2^i.
  function automatic logic [5:0] ecc_model(input logic [31:0] d, input logic [5:0] c);
    logic [5:0] s;
    s = c;
    for (int j = 0; j < 32; j++) if (d[j]) s = s ^ 6'(pos[j]);
    return s;
  endfunction

  task automatic model_step(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] i, output logic [1:0] er, output logic [31:0] es);
    logic        bad_a;
    logic        isrd;
    logic [31:0] rd;
    logic [5:0]  syn;
    bad_a = (a > 32'hC) || (a % 4 != 0);
    isrd = 1'b0; rd = '0; er = 2'b00;
    case (op)
      8'h01: if (bad_a) er = 2'b11;
             else if (a == 32'h0) m_ctrl = d[0];
             else if (a == 32'h4) m_load = d;
             else if (a == 32'h8) m_scratch = d;
             else m_err = m_err & ~d[3:0];
      8'h02: if (bad_a) er = 2'b11;
             else begin
               isrd = 1'b1;
               rd = (a == 32'h0) ? {31'h0, m_ctrl} : (a == 32'h4) ? m_load :
                    (a == 32'h8) ? m_scratch : {28'h0, m_err};
             end
      8'h10: ;
      8'h20: begin
        m_ls = (d == a);
        if (d != a) begin er = 2'b10; m_err[0] = 1'b1; end
      end
`ifdef SAFETY_ISLAND_ECC_EN
      8'h30: begin
        syn = ecc_model(d, a[5:0]);
        m_ecc = syn;
        if (syn != 0) begin er = 2'b10; m_err[1] = 1'b1; end
      end
`endif
      default: begin er = 2'b11; m_err[3] = 1'b1; end
    endcase
    es = isrd ? rd : {16'h0, i, 4'h0, m_err};
  endtask

  // Issue one request from the idle phase, check the completion, then check ready drops.
  task automatic txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] i);
    logic [1:0]  er;
    logic [31:0] es;
    int n;
    model_step(op, a, d, i, er, es);
    bus.opcode = op; bus.addr = a; bus.data = d; bus.id = i; bus.valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.ready && n < 8);
    bus.valid = 1'b0;
    chk("latency", n, 2);
    chk("resp", bus.resp, er);
    chk("status", bus.status, es);
    chk("error", error, m_err != 0);
    chk("lockstep_match", lockstep_match, m_ls);
    chk("ecc_status", ecc_status, m_ecc);
    chk("wdg_timeout", wdg_timeout, m_to);
    @(posedge clk); #1;
    chk("ready_pulse", bus.ready, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.ready, 0);
    chk({tag, "_resp"}, bus.resp, 0);
    chk({tag, "_status"}, bus.status, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_ls"}, lockstep_match, 1);
    chk({tag, "_ecc"}, ecc_status, 0);
    chk({tag, "_wdg"}, wdg_timeout, 0);
  endtask

  initial begin
    int p;
    int k;
    logic [7:0]  op;
    logic [31:0] a, d;
    n_chk = 0; n_fail = 0;
    p = 2;
    for (int j = 0; j < 32; j++) begin
      p++;
      while ((p & (p - 1)) == 0) p++;
      pos[j] = p;
    end
    model_reset();
    rst_n = 1'b0; bus.valid = 1'b0; bus.opcode = '0; bus.addr = '0; bus.data = '0; bus.id = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    txn(8'h01, 32'h8, 32'hDEADBEEF, 8'h01);
    txn(8'h02, 32'h8, 32'h0, 8'h02);
    chk("scratch_readback", bus.status, 32'hDEADBEEF);

    txn(8'h20, 32'h1235, 32'h1234, 8'h5A);
    chk("ls_status", bus.status, 32'h00005A01);
    chk("ls_resp", bus.resp, 2'b10);
    txn(8'h01, 32'hC, 32'h1, 8'h03);
    chk("w1c_error", error, 0);

    txn(8'h30, 32'h0, 32'h1, 8'h04);
`ifdef SAFETY_ISLAND_ECC_EN
    chk("ecc_syn_bit0", ecc_status, 6'h03);
    chk("ecc_resp_bad", bus.resp, 2'b10);
`else
    chk("ecc_off_resp", bus.resp, 2'b11);
    chk("ecc_off_status", ecc_status, 6'h00);
`endif
    txn(8'h30, 32'h0, 32'h0, 8'h05);
    txn(8'h01, 32'hC, 32'hF, 8'h06);

    // Watchdog: L=10 must time out 11 cycles after the CTRL write's ACK.
    txn(8'h01, 32'h4, 32'd10, 8'h07);
    txn(8'h01, 32'h0, 32'h1, 8'h08);
    k = 1;
    while (!wdg_timeout && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("wdg_delay", k, 11);
    m_err[2] = 1'b1; m_to = 1'b1;
    chk("wdg_error", error, 1);
    txn(8'h10, 32'h0, 32'h0, 8'h09);
    chk("wdg_kick_clear", wdg_timeout, 0);
    m_to = 1'b0;
    txn(8'h01, 32'h0, 32'h0, 8'h0A);
    txn(8'h01, 32'hC, 32'h4, 8'h0B);

    txn(8'h7F, 32'h0, 32'h0, 8'h0C);
    chk("bad_op_resp", bus.resp, 2'b11);
    chk("bad_op_err3", bus.status[3], 1);
    txn(8'h02, 32'h10, 32'h0, 8'h0D);
    chk("bad_addr_resp", bus.resp, 2'b11);

    for (int t = 0; t < 150; t++) begin
      d = $urandom;
      case ($urandom_range(0, 5))
        0, 1: begin
          op = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
          a = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 3)) << 2 : $urandom;
          if (a == 32'h0) d[0] = 1'b0;
        end
        2: begin op = 8'h10; a = $urandom; end
        3: begin op = 8'h20; a = ($urandom_range(0, 1) == 0) ? d : $urandom; end
        4: begin
          op = 8'h30; a = $urandom;
          if ($urandom_range(0, 2) == 0) begin d = 0; a[5:0] = 6'h0; end
        end
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == 8'h01 || op == 8'h02 || op == 8'h10 || op == 8'h20 || op == 8'h30)
            op = 8'($urandom_range(0, 255));
          a = $urandom;
        end
      endcase
      txn(op, a, d, 8'($urandom_range(0, 255)));
    end

    // Reset in EXEC aborts the transaction with no completion.
    bus.opcode = 8'h01; bus.addr = 32'h8; bus.data = 32'h55; bus.id = 8'hEE; bus.valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_exec");
    bus.valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    k = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.ready) k++;
    end
    chk("rst_no_ack", k, 0);
    txn(8'h02, 32'h8, 32'h0, 8'h21);
    txn(8'h20, 32'h77, 32'h77, 8'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
